// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul index sequencer.
// Holds the sequencer state enum, default loop maxima and a width helper.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

  localparam int ROWS_MAX_DEF  = 4;
  localparam int COLS_MAX_DEF  = 4;
  localparam int DEPTH_MAX_DEF = 4;

  // Index width for a loop of up to v iterations, never below 1 bit.
  function automatic int idx_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/matmul_index_sequencer_if.sv
// Handshake/bus bundle between control FSM and the index sequencer.
// master: ce/start/bounds out, indices+flags in; slave is the mirror.
// Optional a_addr/b_addr exist only with MATSEQ_LINEAR_ADDR_EN.
interface matmul_index_sequencer_if #(
  parameter int RW = 2,
  parameter int CW = 2,
  parameter int KW = 2
);

  logic          ce;
  logic          start;
  logic [RW:0]   n_rows;
  logic [CW:0]   n_cols;
  logic [KW:0]   n_depth;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [KW-1:0] k;
  logic          valid;
  logic          first_k;
  logic          last_k;
  logic          busy;
  logic          done;
`ifdef MATSEQ_LINEAR_ADDR_EN
  logic [RW+KW-1:0] a_addr;
  logic [KW+CW-1:0] b_addr;
`endif

  modport master (
    output ce, start, n_rows, n_cols, n_depth,
    input  row, col, k, valid, first_k,
    input  last_k, busy, done
`ifdef MATSEQ_LINEAR_ADDR_EN
    , input a_addr, b_addr
`endif
  );

  modport slave (
    input  ce, start, n_rows, n_cols, n_depth,
    output row, col, k, valid, first_k,
    output last_k, busy, done
`ifdef MATSEQ_LINEAR_ADDR_EN
    , output a_addr, b_addr
`endif
  );

endinterface

// File: rtl/wrap_counter.sv
// One loop level: counts 0..bound-1 on inc, wraps to 0 and flags wrap.
// Ports: clk, mr (sync active-low), clr, inc, bound, cnt, wrap (carry out).
module wrap_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         mr,
  input  logic         clr,
  input  logic         inc,
  input  logic [W:0]   bound,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_end;

  assign at_end = ({1'b0, cnt_q} == bound - (W+1)'(1));
  assign wrap   = inc && at_end;
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = at_end ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!mr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matmul_index_sequencer.sv
// Row/col/k loop-index generator with start/busy/done and MAC flags.
// Ports: clk, mr (sync active-low), s (slave modport of the bundle).
// Optional linear A/B addresses under MATSEQ_LINEAR_ADDR_EN.
module matmul_index_sequencer
  import matmul_pkg::*;
#(
  parameter int ROWS_MAX  = ROWS_MAX_DEF,
  parameter int COLS_MAX  = COLS_MAX_DEF,
  parameter int DEPTH_MAX = DEPTH_MAX_DEF
) (
  input  logic clk,
  input  logic mr,
  matmul_index_sequencer_if.slave s
);

  localparam int RW = idx_w(ROWS_MAX);
  localparam int CW = idx_w(COLS_MAX);
  localparam int KW = idx_w(DEPTH_MAX);

  seq_state_t    state_q, state_d;
  logic [RW:0]   rows_q, rows_d;
  logic [CW:0]   cols_q, cols_d;
  logic [KW:0]   depth_q, depth_d;

  logic [RW:0]   rows_lim;
  logic [CW:0]   cols_lim;
  logic [KW:0]   depth_lim;
  logic          all_nz;

  logic          run;
  logic          fire;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic [KW-1:0] k_idx;
  logic          k_wrap;
  logic          col_wrap;
  logic          row_wrap;

  assign rows_lim  = (s.n_rows > (RW+1)'(ROWS_MAX))
                   ? (RW+1)'(ROWS_MAX) : s.n_rows;
  assign cols_lim  = (s.n_cols > (CW+1)'(COLS_MAX))
                   ? (CW+1)'(COLS_MAX) : s.n_cols;
  assign depth_lim = (s.n_depth > (KW+1)'(DEPTH_MAX))
                   ? (KW+1)'(DEPTH_MAX) : s.n_depth;
  assign all_nz    = (|s.n_rows) && (|s.n_cols) && (|s.n_depth);

  assign run  = (state_q == RUN);
  assign fire = run && s.ce;

  // Carry chain: k wraps into col, col wraps into row; a row wrap
  // is the final beat of the whole sequence.
  wrap_counter #(.W(KW)) u_k (
    .clk   (clk),
    .mr    (mr),
    .clr   (!run),
    .inc   (fire),
    .bound (depth_q),
    .cnt   (k_idx),
    .wrap  (k_wrap)
  );

  wrap_counter #(.W(CW)) u_col (
    .clk   (clk),
    .mr    (mr),
    .clr   (!run),
    .inc   (k_wrap),
    .bound (cols_q),
    .cnt   (col_idx),
    .wrap  (col_wrap)
  );

  wrap_counter #(.W(RW)) u_row (
    .clk   (clk),
    .mr    (mr),
    .clr   (!run),
    .inc   (col_wrap),
    .bound (rows_q),
    .cnt   (row_idx),
    .wrap  (row_wrap)
  );

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    depth_d = depth_q;
    unique case (state_q)
      IDLE: begin
        if (s.start) begin
          if (all_nz) begin
            state_d = RUN;
            rows_d  = rows_lim;
            cols_d  = cols_lim;
            depth_d = depth_lim;
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        if (row_wrap) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!mr) begin
      state_q <= IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      depth_q <= depth_d;
    end
  end

  assign s.row     = row_idx;
  assign s.col     = col_idx;
  assign s.k       = k_idx;
  assign s.valid   = run;
  assign s.busy    = run;
  assign s.done    = (state_q == FIN);
  assign s.first_k = run && (k_idx == '0);
  assign s.last_k  = run
                   && ({1'b0, k_idx} == depth_q - (KW+1)'(1));

`ifdef MATSEQ_LINEAR_ADDR_EN
  localparam int AW = RW + KW;
  localparam int BW = KW + CW;

  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [BW-1:0] b_addr_q, b_addr_d;

  // a = row*depth+k, b = k*cols+col, tracked by add/subtract only.
  always_comb begin
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    if (!run) begin
      a_addr_d = '0;
      b_addr_d = '0;
    end else if (fire) begin
      if (row_wrap) begin
        a_addr_d = '0;
        b_addr_d = '0;
      end else if (!k_wrap) begin
        a_addr_d = a_addr_q + AW'(1);
        b_addr_d = b_addr_q + BW'(cols_q);
      end else if (!col_wrap) begin
        // back to this row's base, b restarts at the next column
        a_addr_d = a_addr_q - AW'(depth_q) + AW'(1);
        b_addr_d = BW'(col_idx) + BW'(1);
      end else begin
        a_addr_d = a_addr_q + AW'(1);
        b_addr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!mr) begin
      a_addr_q <= '0;
      b_addr_q <= '0;
    end else begin
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
    end
  end

  assign s.a_addr = a_addr_q;
  assign s.b_addr = b_addr_q;
`endif

endmodule

// File: tb/tb_matmul_index_sequencer.sv
// Self-checking bench for matmul_index_sequencer (default 4x4x4 maxima).
// Table-driven runs plus hand sequences for zero bound and mid-run reset.
module tb_matmul_index_sequencer;

  logic clk;
  logic mr;
  int   n_cmp;
  int   n_fail;

  matmul_index_sequencer_if #(.RW(2), .CW(2), .KW(2)) sif ();

  matmul_index_sequencer dut (
    .clk (clk),
    .mr  (mr),
    .s   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int r;
    int c;
    int d;
    bit tog;
    int fires;
    int nfirst;
    int nlast;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > 4) ? 4 : v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, int'(sif.valid), 0);
    chk({tag, " busy"}, int'(sif.busy), 0);
    chk({tag, " done"}, int'(sif.done), 0);
    chk({tag, " first_k"}, int'(sif.first_k), 0);
    chk({tag, " last_k"}, int'(sif.last_k), 0);
    chk({tag, " row"}, int'(sif.row), 0);
    chk({tag, " col"}, int'(sif.col), 0);
    chk({tag, " k"}, int'(sif.k), 0);
  endtask

  // Start a run, walk every beat against a nested-loop model and
  // check the done pulse and return to idle. Called at a negedge.
  task automatic run_seq(input vec_t v, input string tag);
    int rr, cc, dd;
    int er, ec, ek;
    int fires, nf, nl, obs;
    bit got_done;
    bit cur_ce;
    rr = clampv(v.r);
    cc = clampv(v.c);
    dd = clampv(v.d);
    er = 0; ec = 0; ek = 0;
    fires = 0; nf = 0; nl = 0; obs = 0;
    got_done = 1'b0;
    sif.start   = 1'b1;
    sif.n_rows  = 3'(v.r);
    sif.n_cols  = 3'(v.c);
    sif.n_depth = 3'(v.d);
    sif.ce      = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    while (!got_done && obs < 600) begin
      if (sif.done) begin
        got_done = 1'b1;
        chk({tag, " valid@done"}, int'(sif.valid), 0);
        chk({tag, " row@done"}, int'(sif.row), 0);
        if (!v.tog) chk({tag, " done cycle"}, obs, v.fires);
      end else begin
        chk($sformatf("%s valid o%0d", tag, obs), int'(sif.valid), 1);
        chk($sformatf("%s busy o%0d", tag, obs), int'(sif.busy), 1);
        chk($sformatf("%s row o%0d", tag, obs), int'(sif.row), er);
        chk($sformatf("%s col o%0d", tag, obs), int'(sif.col), ec);
        chk($sformatf("%s k o%0d", tag, obs), int'(sif.k), ek);
        chk($sformatf("%s first o%0d", tag, obs),
            int'(sif.first_k), (ek == 0) ? 1 : 0);
        chk($sformatf("%s last o%0d", tag, obs),
            int'(sif.last_k), (ek == dd - 1) ? 1 : 0);
`ifdef MATSEQ_LINEAR_ADDR_EN
        chk($sformatf("%s a_addr o%0d", tag, obs),
            int'(sif.a_addr), er * dd + ek);
        chk($sformatf("%s b_addr o%0d", tag, obs),
            int'(sif.b_addr), ek * cc + ec);
`endif
        cur_ce = v.tog ? (obs % 2 == 0) : 1'b1;
        sif.ce = cur_ce;
        // a start with other bounds mid-run must be ignored
        if (v.tog && obs >= 2 && obs <= 4) begin
          sif.start   = 1'b1;
          sif.n_rows  = 3'd1;
          sif.n_cols  = 3'd1;
          sif.n_depth = 3'd1;
        end else begin
          sif.start = 1'b0;
        end
        if (cur_ce) begin
          fires++;
          if (ek == 0) nf++;
          if (ek == dd - 1) nl++;
          ek++;
          if (ek == dd) begin
            ek = 0;
            ec++;
            if (ec == cc) begin
              ec = 0;
              er++;
            end
          end
        end
      end
      obs++;
      @(negedge clk);
    end
    sif.start = 1'b0;
    sif.ce    = 1'b1;
    chk({tag, " done seen"}, int'(got_done), 1);
    chk({tag, " fires"}, fires, v.fires);
    chk({tag, " first_k count"}, nf, v.nfirst);
    chk({tag, " last_k count"}, nl, v.nlast);
    chk_zero({tag, " idle"});
  endtask

  vec_t vecs [7];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{3, 3, 3, 1'b0, 27, 9, 9};
    vecs[1] = '{2, 2, 1, 1'b0, 4, 4, 4};
    vecs[2] = '{2, 2, 2, 1'b1, 8, 4, 4};
    vecs[3] = '{7, 4, 4, 1'b0, 64, 16, 16};
    vecs[4] = '{1, 1, 1, 1'b0, 1, 1, 1};
    vecs[5] = '{4, 1, 3, 1'b0, 12, 4, 4};
    vecs[6] = '{2, 3, 2, 1'b0, 12, 6, 6};

    mr          = 1'b0;
    sif.ce      = 1'b0;
    sif.start   = 1'b1;
    sif.n_rows  = 3'd2;
    sif.n_cols  = 3'd2;
    sif.n_depth = 3'd2;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    sif.start = 1'b0;
    mr        = 1'b1;
    @(negedge clk);
    chk_zero("post reset idle");

    for (int i = 0; i < 7; i++) begin
      run_seq(vecs[i], $sformatf("vec%0d", i));
    end

    // zero column bound: straight to FIN, no beat
    sif.start   = 1'b1;
    sif.n_rows  = 3'd2;
    sif.n_cols  = 3'd0;
    sif.n_depth = 3'd2;
    @(negedge clk);
    chk("zb valid", int'(sif.valid), 0);
    chk("zb done", int'(sif.done), 1);
    chk("zb busy", int'(sif.busy), 0);
    sif.n_cols = 3'd2;
    @(negedge clk);
    chk("zb start in FIN ignored valid", int'(sif.valid), 0);
    chk("zb done cleared", int'(sif.done), 0);
    sif.start = 1'b0;
    @(negedge clk);
    chk_zero("zb idle");

    // reset at beat 5 of a 4x4x4 run
    sif.start   = 1'b1;
    sif.n_rows  = 3'd4;
    sif.n_cols  = 3'd4;
    sif.n_depth = 3'd4;
    sif.ce      = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst beat5 row", int'(sif.row), 0);
    chk("rst beat5 col", int'(sif.col), 1);
    chk("rst beat5 k", int'(sif.k), 1);
    mr = 1'b0;
    @(negedge clk);
    chk_zero("mid-run reset");
    mr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no done after reset %0d", i),
          int'(sif.done), 0);
      chk($sformatf("no valid after reset %0d", i),
          int'(sif.valid), 0);
    end
    run_seq('{1, 2, 2, 1'b0, 4, 2, 2}, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
